// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor: one SEG-bit ripple segment resolved per stage,
// carry registered between segments, global-stall valid/ready handshake on both sides.
module pipelined_addsub #(
    parameter int unsigned N   = 32,
    parameter int unsigned SEG = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic         zero
);

    localparam int unsigned STAGES = N / SEG;
    localparam int unsigned LAST   = STAGES - 1;

    logic         valid_d   [STAGES];
    logic         valid_q   [STAGES];
    logic [N-1:0] a_d       [STAGES];
    logic [N-1:0] a_q       [STAGES];
    logic [N-1:0] bx_d      [STAGES];
    logic [N-1:0] bx_q      [STAGES];
    logic [N-1:0] sum_d     [STAGES];
    logic [N-1:0] sum_q     [STAGES];
    logic         carry_d   [STAGES];
    logic         carry_q   [STAGES];
    logic         overflow_d;
    logic         overflow_q;
    logic         zero_d;
    logic         zero_q;

    logic         adv;
    logic [N-1:0] bx_in;
    logic [SEG:0] slice;

    function automatic logic [SEG:0] add_slice(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           c
    );
        return {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c};
    endfunction

    // A stalled output holds the whole pipeline; bubbles are never collapsed.
    assign adv      = !valid_q[LAST] || out_ready;
    assign in_ready = adv;

    always_comb begin
        bx_in = sub ? ~B : B;
        slice = add_slice(A[SEG-1:0], bx_in[SEG-1:0], sub);

        valid_d[0]           = in_valid;
        a_d[0]               = A;
        bx_d[0]              = bx_in;
        carry_d[0]           = slice[SEG];
        sum_d[0]             = '0;
        sum_d[0][SEG-1:0]    = slice[SEG-1:0];

        for (int unsigned k = 1; k < STAGES; k++) begin
            slice = add_slice(a_q[k-1][k*SEG +: SEG], bx_q[k-1][k*SEG +: SEG], carry_q[k-1]);
            valid_d[k]              = valid_q[k-1];
            a_d[k]                  = a_q[k-1];
            bx_d[k]                 = bx_q[k-1];
            carry_d[k]              = slice[SEG];
            sum_d[k]                = sum_q[k-1];
            sum_d[k][k*SEG +: SEG]  = slice[SEG-1:0];
        end

        // Flags come from the full result as it forms in the last stage.
        overflow_d = (a_d[LAST][N-1] ~^ bx_d[LAST][N-1]) & (sum_d[LAST][N-1] ^ a_d[LAST][N-1]);
        zero_d     = ~|sum_d[LAST];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                bx_q[k]    <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
            end
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                a_q[k]     <= a_d[k];
                bx_q[k]    <= bx_d[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
            end
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (N=32, SEG=8): directed and random operations
// against an arithmetic reference model with a latency/occupancy tracker.
module tb_pipelined_addsub;

    localparam int N      = 32;
    localparam int SEG    = 8;
    localparam int STAGES = N / SEG;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;

    always #5 clk = ~clk;

    pipelined_addsub #(.N(N), .SEG(SEG)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    // In-flight tracker: slot i holds the result expected i+1 edges after acceptance.
    logic m_v [STAGES];
    res_t m_r [STAGES];
    res_t got_q [$];
    int   issued   = 0;
    int   consumed = 0;
    int   errors   = 0;
    int   checks   = 0;

    function automatic res_t ref_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        res_t   r;
        longint sa;
        longint sb;
        longint sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            r.sum  = a - b;
            r.cout = (a >= b);
            sr     = sa - sb;
        end else begin
            r.sum  = a + b;
            r.cout = (({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF);
            sr     = sa + sb;
        end
        r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles, input logic keep_valid);
        int dropped;
        dropped = 0;
        for (int k = 0; k < STAGES; k++) if (m_v[k]) dropped++;
        issued -= dropped;
        for (int k = 0; k < STAGES; k++) m_v[k] = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst       = 1'b1;
            in_valid  = keep_valid;
            A         = $urandom;
            B         = $urandom;
            sub       = 1'($urandom_range(0, 1));
            out_ready = 1'b0;
            #1;
            if (i > 0) begin
                chk("rst_out_valid", out_valid, 1'b0);
                chk("rst_sum",       sum,       '0);
                chk("rst_cout",      cout,      1'b0);
                chk("rst_overflow",  overflow,  1'b0);
                chk("rst_zero",      zero,      1'b0);
                chk("rst_in_ready",  in_ready,  1'b1);
            end
        end
    endtask

    task automatic step(input logic iv, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic ordy, output logic accepted);
        logic adv;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = iv;
        A         = a;
        B         = b;
        sub       = s;
        out_ready = ordy;
        #1;
        adv = !m_v[STAGES-1] || ordy;
        chk("in_ready",  in_ready,  adv);
        chk("out_valid", out_valid, m_v[STAGES-1]);
        if (m_v[STAGES-1]) begin
            chk("sum",      sum,      m_r[STAGES-1].sum);
            chk("cout",     cout,     m_r[STAGES-1].cout);
            chk("overflow", overflow, m_r[STAGES-1].ovf);
            chk("zero",     zero,     m_r[STAGES-1].zero);
            if (ordy) begin
                got_q.push_back(res_t'{sum, cout, overflow, zero});
                consumed++;
            end
        end
        accepted = adv && iv;
        if (adv) begin
            for (int k = STAGES - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1];
                m_r[k] = m_r[k-1];
            end
            m_v[0] = iv;
            m_r[0] = ref_op(a, b, s);
            if (iv) issued++;
        end
    endtask

    task automatic idle(input int cycles);
        logic acc;
        for (int i = 0; i < cycles; i++) step(1'b0, $urandom, $urandom, 1'b0, 1'b1, acc);
    endtask

    initial begin
        logic         acc;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rs;
        int           n;
        int           cyc;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < STAGES; k++) m_v[k] = 1'b0;

        // 1: reset for two cycles
        do_reset(2, 1'b0);

        // 2-3: directed carry chain, signed overflow, subtract to zero, wrap-around
        step(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, acc);
        idle(STAGES + 1);
        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, acc);
        step(1'b1, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, acc);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, acc);
        step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, acc);
        idle(STAGES + 1);
        chk("directed_count", got_q.size(), 5);
        if (got_q.size() >= 5) begin
            chk("d0_sum",  got_q[0].sum,  32'h0000_0100);
            chk("d0_cout", got_q[0].cout, 1'b0);
            chk("d0_ovf",  got_q[0].ovf,  1'b0);
            chk("d0_zero", got_q[0].zero, 1'b0);
            chk("d1_sum",  got_q[1].sum,  32'h8000_0000);
            chk("d1_ovf",  got_q[1].ovf,  1'b1);
            chk("d1_cout", got_q[1].cout, 1'b0);
            chk("d2_sum",  got_q[2].sum,  32'h0000_0000);
            chk("d2_zero", got_q[2].zero, 1'b1);
            chk("d2_cout", got_q[2].cout, 1'b1);
            chk("d3_sum",  got_q[3].sum,  32'h0000_0000);
            chk("d3_cout", got_q[3].cout, 1'b1);
            chk("d4_sum",  got_q[4].sum,  32'h7FFF_FFFF);
            chk("d4_ovf",  got_q[4].ovf,  1'b1);
        end

        // 4: back-to-back stream of 8 random operations
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            step(1'b1, ra, rb, 1'($urandom_range(0, 1)), 1'b1, acc);
        end
        idle(STAGES + 1);

        // 5: stream with the consumer stalled for 6 cycles, then random backpressure
        n   = 0;
        cyc = 0;
        ra  = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
        while (n < 10 && cyc < 200) begin
            step(1'b1, ra, rb, rs, (cyc >= 6) ? ($urandom_range(0, 3) != 0) : 1'b0, acc);
            if (acc) begin
                n++;
                ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        chk("stall_stream_done", n, 10);
        idle(STAGES + 2);

        // 6: reset with three operations in flight; none may emerge
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, acc);
        do_reset(2, 1'b1);
        idle(STAGES + 4);

        chk("results_conserved", consumed, issued);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
